memory_burst_operation: RTL and testbench

//  Parametrised successor to the single-beat memory read/write phase sequencer in the CNN accelerator.

---
 rtl/memory_burst_operation_if.sv | 40 ++++
 rtl/memory_burst_operation.sv | 122 ++++++++++++
 tb/tb_memory_burst_operation.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_burst_operation_if.sv
// Command, write-beat, read-return and memory-side signals of the burst sequencer.
// The slave modport is the sequencer's view of the bundle.
interface memory_burst_operation_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 8,
  parameter int unsigned LW = 8
);
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_write_i;
  logic [AW-1:0] cmd_base_i;
  logic [LW-1:0] cmd_len_i;
  logic          stage_finish_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          mem_rd_en_o;
  logic          mem_wr_en_o;
  logic [AW-1:0] address_o;
  logic [DW-1:0] mem_wr_data_o;
  logic [DW-1:0] mem_rd_data_i;
  logic          busy_o;
  logic          done_o;

  modport slave (
    input  cmd_valid_i, cmd_write_i, cmd_base_i, cmd_len_i, stage_finish_i,
           wr_data_i, wr_valid_i, mem_rd_data_i,
    output cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o, mem_rd_en_o, mem_wr_en_o,
           address_o, mem_wr_data_o, busy_o, done_o
  );

  modport master (
    output cmd_valid_i, cmd_write_i, cmd_base_i, cmd_len_i, stage_finish_i,
           wr_data_i, wr_valid_i, mem_rd_data_i,
    input  cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o, mem_rd_en_o, mem_wr_en_o,
           address_o, mem_wr_data_o, busy_o, done_o
  );
endinterface

// File: rtl/memory_burst_operation.sv
// Burst sequencer: takes one read/write burst command and drives a single-port buffer memory
// with one beat per cycle, a fixed address stride and a latency-matched read-return path.
module memory_burst_operation #(
  parameter int unsigned                      ADDRESS_BUS_BIT_WIDTH = 32,
  parameter int unsigned                      DATA_BIT_WIDTH        = 8,
  parameter int unsigned                      LEN_BIT_WIDTH         = 8,
  parameter logic [ADDRESS_BUS_BIT_WIDTH-1:0] ADDRESS_STRIDE        = 'h1,
  parameter logic [ADDRESS_BUS_BIT_WIDTH-1:0] INI_ADDRESS_BUS       = '0,
  parameter int unsigned                      MEM_READ_LATENCY      = 1
) (
  input logic                     clk,
  input logic                     layer_reset,
  memory_burst_operation_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StWriteBurst,
    StReadBurst,
    StReadDrain,
    StDone
  } state_e;

  localparam logic [LEN_BIT_WIDTH-1:0] LenOne = {{(LEN_BIT_WIDTH-1){1'b0}}, 1'b1};

  state_e                           state_q;
  logic [ADDRESS_BUS_BIT_WIDTH-1:0] address_q;
  logic [LEN_BIT_WIDTH-1:0]         cnt_q;
  logic [MEM_READ_LATENCY-1:0]      rd_pipe_q;
  logic [DATA_BIT_WIDTH-1:0]        wr_data;
  logic [DATA_BIT_WIDTH-1:0]        rd_data;
  logic                             wr_ready;
  logic                             wr_en;
  logic                             rd_en;
  logic                             last_beat;

  // stage_finish_i suppresses every enable in the very cycle it is seen.
  always_comb begin
    wr_ready  = (state_q == StWriteBurst) && !bus.stage_finish_i;
    wr_en     = wr_ready && bus.wr_valid_i;
    rd_en     = (state_q == StReadBurst) && !bus.stage_finish_i;
    last_beat = (cnt_q == LenOne);
  end

  assign wr_data           = bus.wr_data_i;
  assign rd_data           = bus.mem_rd_data_i;
  assign bus.mem_wr_data_o = wr_data;
  assign bus.rd_data_o     = rd_data;
  assign bus.wr_ready_o    = wr_ready;
  assign bus.mem_wr_en_o   = wr_en;
  assign bus.mem_rd_en_o   = rd_en;
  assign bus.rd_valid_o    = rd_pipe_q[MEM_READ_LATENCY-1];
  assign bus.address_o     = address_q;
  assign bus.cmd_ready_o   = (state_q == StIdle);
  assign bus.busy_o        = (state_q != StIdle);
  assign bus.done_o        = (state_q == StDone);

  always_ff @(posedge clk) begin
    if (layer_reset) begin
      state_q   <= StIdle;
      address_q <= INI_ADDRESS_BUS;
      cnt_q     <= '0;
      rd_pipe_q <= '0;
    end else begin
      // Read-enable delay line; its tail marks the cycle the memory data is valid.
      rd_pipe_q[0] <= rd_en;
      for (int i = 1; i < MEM_READ_LATENCY; i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end

      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid_i) begin
            address_q <= bus.cmd_base_i;
            cnt_q     <= bus.cmd_len_i;
            if (bus.cmd_len_i == '0) begin
              state_q <= StDone;
            end else if (bus.cmd_write_i) begin
              state_q <= StWriteBurst;
            end else begin
              state_q <= StReadBurst;
            end
          end
        end
        StWriteBurst: begin
          if (bus.stage_finish_i) begin
            state_q <= StDone;
          end else if (bus.wr_valid_i) begin
            address_q <= address_q + ADDRESS_STRIDE;
            cnt_q     <= cnt_q - LenOne;
            if (last_beat) begin
              state_q <= StDone;
            end
          end
        end
        StReadBurst: begin
          if (bus.stage_finish_i) begin
            state_q <= StReadDrain;
          end else begin
            address_q <= address_q + ADDRESS_STRIDE;
            cnt_q     <= cnt_q - LenOne;
            if (last_beat) begin
              state_q <= StReadDrain;
            end
          end
        end
        StReadDrain: begin
          if (rd_pipe_q == '0) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_burst_operation.sv
// Directed bench: two sequencer instances (stride 1/latency 1 and stride 2/latency 2) with
// small behavioural memories, checked cycle by cycle against hand-computed expectations.
module tb_memory_burst_operation;

  logic clk = 1'b0;
  logic layer_reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  memory_burst_operation_if #(.AW(32), .DW(8), .LW(8)) b0 ();
  memory_burst_operation_if #(.AW(32), .DW(8), .LW(8)) b1 ();

  memory_burst_operation #(
    .ADDRESS_BUS_BIT_WIDTH(32), .DATA_BIT_WIDTH(8), .LEN_BIT_WIDTH(8),
    .ADDRESS_STRIDE(32'h1), .INI_ADDRESS_BUS(32'h0), .MEM_READ_LATENCY(1)
  ) dut0 (
    .clk(clk), .layer_reset(layer_reset), .bus(b0)
  );

  memory_burst_operation #(
    .ADDRESS_BUS_BIT_WIDTH(32), .DATA_BIT_WIDTH(8), .LEN_BIT_WIDTH(8),
    .ADDRESS_STRIDE(32'h2), .INI_ADDRESS_BUS(32'h100), .MEM_READ_LATENCY(2)
  ) dut1 (
    .clk(clk), .layer_reset(layer_reset), .bus(b1)
  );

  // Behavioural memories, preloaded while reset is high.
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  logic [7:0] rd1_s1;

  always @(posedge clk) begin
    if (layer_reset) begin
      for (int i = 0; i < 16; i++) begin
        mem0[i] <= (i < 4) ? 8'(i + 1) : 8'h00;
        mem1[i] <= (i == 0) ? 8'hA5 : 8'h00;
      end
      b0.mem_rd_data_i <= 8'h00;
      b1.mem_rd_data_i <= 8'h00;
      rd1_s1           <= 8'h00;
    end else begin
      if (b0.mem_wr_en_o) mem0[b0.address_o[3:0]] <= b0.mem_wr_data_o;
      if (b0.mem_rd_en_o) b0.mem_rd_data_i <= mem0[b0.address_o[3:0]];
      if (b1.mem_wr_en_o) mem1[b1.address_o[3:0]] <= b1.mem_wr_data_o;
      if (b1.mem_rd_en_o) rd1_s1 <= mem1[b1.address_o[3:0]];
      b1.mem_rd_data_i <= rd1_s1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [5:0] vpat;
  int         addr3 [6];
  int         nb;
  int         nwr;
  int         nrd;
  int         nval;
  logic [31:0] wrap_addr [2];

  initial begin
    layer_reset = 1'b1;
    b0.cmd_valid_i = 1'b0; b0.cmd_write_i = 1'b0; b0.cmd_base_i = '0; b0.cmd_len_i = '0;
    b0.stage_finish_i = 1'b0; b0.wr_data_i = '0; b0.wr_valid_i = 1'b0;
    b1.cmd_valid_i = 1'b0; b1.cmd_write_i = 1'b0; b1.cmd_base_i = '0; b1.cmd_len_i = '0;
    b1.stage_finish_i = 1'b0; b1.wr_data_i = '0; b1.wr_valid_i = 1'b0;
    tick();
    tick();

    // Reset state
    #1;
    chk_b("rst_cmd_ready", b0.cmd_ready_o, 1'b1);
    chk_b("rst_busy", b0.busy_o, 1'b0);
    chk_b("rst_done", b0.done_o, 1'b0);
    chk_b("rst_rd_valid", b0.rd_valid_o, 1'b0);
    chk_b("rst_rd_en", b0.mem_rd_en_o, 1'b0);
    chk_b("rst_wr_en", b0.mem_wr_en_o, 1'b0);
    chk_b("rst_wr_ready", b0.wr_ready_o, 1'b0);
    chk_w("rst_addr0", b0.address_o, 32'h0);
    chk_w("rst_addr1", b1.address_o, 32'h100);
    layer_reset = 1'b0;

    // 1: write burst base=4 len=4, data FF..FC
    b0.cmd_valid_i = 1'b1; b0.cmd_write_i = 1'b1; b0.cmd_base_i = 32'd4; b0.cmd_len_i = 8'd4;
    #1;
    chk_b("wr_cmd_ready", b0.cmd_ready_o, 1'b1);
    tick();
    b0.cmd_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b0.wr_valid_i = 1'b1;
      b0.wr_data_i  = 8'(8'hFF - i);
      #1;
      chk_b("wr_en", b0.mem_wr_en_o, 1'b1);
      chk_b("wr_ready", b0.wr_ready_o, 1'b1);
      chk_w("wr_addr", b0.address_o, 32'(4 + i));
      tick();
    end
    b0.wr_valid_i = 1'b0;
    #1;
    chk_b("wr_done", b0.done_o, 1'b1);
    chk_b("wr_done_no_en", b0.mem_wr_en_o, 1'b0);
    chk_w("wr_addr_end", b0.address_o, 32'd8);
    tick();
    chk_b("wr_done_clr", b0.done_o, 1'b0);
    chk_b("wr_idle_busy", b0.busy_o, 1'b0);
    chk_w("wr_mem4", 32'(mem0[4]), 32'hFF);
    chk_w("wr_mem7", 32'(mem0[7]), 32'hFC);

    // 2: read burst base=0 len=4, latency 1
    b0.cmd_valid_i = 1'b1; b0.cmd_write_i = 1'b0; b0.cmd_base_i = 32'd0; b0.cmd_len_i = 8'd4;
    tick();
    b0.cmd_valid_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk_b("rd_en", b0.mem_rd_en_o, k < 4);
      chk_b("rd_valid", b0.rd_valid_o, (k >= 1) && (k <= 4));
      if ((k >= 1) && (k <= 4)) chk_w("rd_data", 32'(b0.rd_data_o), 32'(k));
      if (k < 4) chk_w("rd_addr", b0.address_o, 32'(k));
      chk_b("rd_done", b0.done_o, k == 6);
      chk_b("rd_busy", b0.busy_o, k != 7);
      tick();
    end

    // 3: write with a two-cycle stall, base=8 len=4
    vpat  = 6'b110011;
    addr3 = '{8, 9, 10, 10, 10, 11};
    nb    = 0;
    nwr   = 0;
    b0.cmd_valid_i = 1'b1; b0.cmd_write_i = 1'b1; b0.cmd_base_i = 32'd8; b0.cmd_len_i = 8'd4;
    tick();
    b0.cmd_valid_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      b0.wr_valid_i = vpat[k];
      b0.wr_data_i  = 8'(8'h11 * (nb + 1));
      #1;
      chk_b("stall_wr_en", b0.mem_wr_en_o, vpat[k]);
      chk_w("stall_addr", b0.address_o, 32'(addr3[k]));
      if (b0.mem_wr_en_o) nwr++;
      if (vpat[k]) nb++;
      tick();
    end
    b0.wr_valid_i = 1'b0;
    #1;
    chk_b("stall_done", b0.done_o, 1'b1);
    chk_w("stall_writes", 32'(nwr), 32'd4);
    tick();
    chk_w("stall_mem8", 32'(mem0[8]), 32'h11);
    chk_w("stall_mem10", 32'(mem0[10]), 32'h33);
    chk_w("stall_mem11", 32'(mem0[11]), 32'h44);

    // 3b: stage_finish during a write burst drops that beat
    b0.cmd_valid_i = 1'b1; b0.cmd_write_i = 1'b1; b0.cmd_base_i = 32'd12; b0.cmd_len_i = 8'd4;
    tick();
    b0.cmd_valid_i = 1'b0;
    b0.wr_valid_i  = 1'b1;
    b0.wr_data_i   = 8'h5A;
    #1;
    chk_b("sfw_wr_en0", b0.mem_wr_en_o, 1'b1);
    tick();
    b0.stage_finish_i = 1'b1;
    #1;
    chk_b("sfw_wr_en1", b0.mem_wr_en_o, 1'b0);
    chk_b("sfw_wr_ready1", b0.wr_ready_o, 1'b0);
    tick();
    b0.stage_finish_i = 1'b0;
    b0.wr_valid_i     = 1'b0;
    #1;
    chk_b("sfw_done", b0.done_o, 1'b1);
    chk_w("sfw_addr", b0.address_o, 32'd13);
    tick();
    chk_w("sfw_mem12", 32'(mem0[12]), 32'h5A);
    chk_w("sfw_mem13", 32'(mem0[13]), 32'h00);

    // 4: stage_finish on 2nd cycle of a len=8 read, latency 2
    nrd  = 0;
    nval = 0;
    b1.cmd_valid_i = 1'b1; b1.cmd_write_i = 1'b0; b1.cmd_base_i = 32'd0; b1.cmd_len_i = 8'd8;
    tick();
    b1.cmd_valid_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      b1.stage_finish_i = (k == 1);
      #1;
      chk_b("sfr_rd_en", b1.mem_rd_en_o, k == 0);
      chk_b("sfr_rd_valid", b1.rd_valid_o, k == 2);
      if (k == 2) chk_w("sfr_rd_data", 32'(b1.rd_data_o), 32'hA5);
      chk_b("sfr_done", b1.done_o, k == 4);
      chk_b("sfr_busy", b1.busy_o, k != 5);
      if (b1.mem_rd_en_o) nrd++;
      if (b1.rd_valid_o) nval++;
      tick();
    end
    b1.stage_finish_i = 1'b0;
    chk_w("sfr_reads", 32'(nrd), 32'd1);
    chk_w("sfr_valids", 32'(nval), 32'd1);
    chk_w("sfr_addr_hold", b1.address_o, 32'd2);

    // 5a: len=0 command
    b1.cmd_valid_i = 1'b1; b1.cmd_write_i = 1'b0; b1.cmd_base_i = 32'd40; b1.cmd_len_i = 8'd0;
    tick();
    b1.cmd_valid_i = 1'b0;
    #1;
    chk_b("len0_done", b1.done_o, 1'b1);
    chk_b("len0_rd_en", b1.mem_rd_en_o, 1'b0);
    chk_b("len0_wr_en", b1.mem_wr_en_o, 1'b0);
    chk_w("len0_addr", b1.address_o, 32'd40);
    tick();
    chk_b("len0_done_clr", b1.done_o, 1'b0);
    chk_b("len0_cmd_ready", b1.cmd_ready_o, 1'b1);

    // 5b: address wrap with stride 2
    wrap_addr = '{32'hFFFF_FFFE, 32'h0000_0000};
    b1.cmd_valid_i = 1'b1; b1.cmd_write_i = 1'b1; b1.cmd_base_i = 32'hFFFF_FFFE;
    b1.cmd_len_i = 8'd2;
    tick();
    b1.cmd_valid_i = 1'b0;
    b1.wr_valid_i  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      b1.wr_data_i = 8'(8'hC0 + k);
      #1;
      chk_b("wrap_wr_en", b1.mem_wr_en_o, 1'b1);
      chk_w("wrap_addr", b1.address_o, wrap_addr[k]);
      tick();
    end
    b1.wr_valid_i = 1'b0;
    #1;
    chk_b("wrap_done", b1.done_o, 1'b1);
    tick();
    chk_w("wrap_addr_hold", b1.address_o, 32'h2);
    chk_b("wrap_idle", b1.busy_o, 1'b0);

    // 6: reset in the middle of a read burst
    b0.cmd_valid_i = 1'b1; b0.cmd_write_i = 1'b0; b0.cmd_base_i = 32'd0; b0.cmd_len_i = 8'd4;
    tick();
    b0.cmd_valid_i = 1'b0;
    #1;
    chk_b("mid_rd_en", b0.mem_rd_en_o, 1'b1);
    tick();
    chk_b("mid_rd_valid", b0.rd_valid_o, 1'b1);
    layer_reset = 1'b1;
    tick();
    layer_reset = 1'b0;
    #1;
    chk_b("mrst_cmd_ready", b0.cmd_ready_o, 1'b1);
    chk_b("mrst_busy", b0.busy_o, 1'b0);
    chk_b("mrst_rd_en", b0.mem_rd_en_o, 1'b0);
    chk_b("mrst_rd_valid", b0.rd_valid_o, 1'b0);
    chk_b("mrst_done", b0.done_o, 1'b0);
    chk_b("mrst_wr_ready", b0.wr_ready_o, 1'b0);
    chk_w("mrst_addr0", b0.address_o, 32'h0);
    chk_w("mrst_addr1", b1.address_o, 32'h100);
    tick();
    chk_b("mrst_quiet_done", b0.done_o, 1'b0);
    chk_b("mrst_quiet_valid", b0.rd_valid_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
